task2_fillscreen_top: RTL and testbench
=======================================

// Module: task2_fillscreen_top
// PURPOSE
// - Top level for the lab 2 "fill screen" task.
// - After reset it writes every pixel of a 160x120 VGA frame exactly once, one pixel per clock.
// - Colour of each pixel is its column index mod 8, which gives vertical colour stripes.
// - Drives a pixel-write interface (X, Y, colour, plot) to an external VGA adapter, then
//   raises a done flag on LEDR[0].
// PARAMETERS
// - SCREEN_W  160  columns; x range 0..SCREEN_W-1, fits VGA_X[7:0]
// - SCREEN_H  120  rows; y range 0..SCREEN_H-1, fits VGA_Y[6:0]
// PORTS
// - CLOCK_50    in   1   system clock, 50 MHz, rising edge
// - KEY         in   4   KEY[3] = reset, asynchronous, active-low; KEY[2:0] unused
// - SW          in   10  unused
// - LEDR        out  10  LEDR[0] = done; LEDR[9:1] = 0
// - HEX0..HEX5  out  7   each; active-low segments; see CONFIGURATION
// - VGA_R/G/B   out  8   each; tied 0 (analog path lives in the external adapter)
// - VGA_HS, VGA_VS  out  1   tied 1
// - VGA_CLK     out  1   tied 0
// - VGA_X       out  8   pixel column
// - VGA_Y       out  7   pixel row
// - VGA_COLOUR  out  3   pixel colour
// - VGA_PLOT    out  1   write strobe; one pixel is written per cycle while high
// BEHAVIOUR
// - Clocking/reset: single clock domain. Reset is asynchronous and active-low on KEY[3].
// - All pixel outputs and LEDR[0] are registered.
// - Reset values: state = INIT; VGA_X = 0, VGA_Y = 0, VGA_COLOUR = 0, VGA_PLOT = 0, LEDR = 0.
// - FSM states: INIT -> FILL -> DONE.
// - INIT: lasts one clock after reset release. On that edge go to FILL and present
//   (x=0, y=0, colour=0, plot=1).
// - FILL: on each edge y increments. When y == SCREEN_H-1, set y = 0 and x = x+1.
//   Colour is always x[2:0] for the x being presented.
// - Scan order is column-major: (0,0), (0,1) .. (0,119), (1,0) .. (159,119).
// - End of FILL: on the edge after (159,119) is presented, set plot = 0, LEDR[0] = 1,
//   go to DONE. X and Y hold their last values.
// - Latency: exactly 19200 plot cycles. LEDR[0] rises on the 19201st rising edge after
//   KEY[3] deasserts.
// - DONE: terminal. LEDR[0] stays 1 and plot stays 0 until the next reset.
// - No pixel is ever written twice per frame.
// - Reset mid-fill: outputs return to reset values at once (asynchronous). The fill
//   restarts from (0,0) after release. LEDR[0] is 0 throughout.
// - Width rules: x counter is 8 bits and never exceeds 159; y counter is 7 bits and never
//   exceeds 119. No out-of-range coordinate is presented while plot = 1.
// CONFIGURATION
// - Macro: FILL_HEX_STATUS_EN.
// - Defined: HEX1:HEX0 show current x in hex. HEX3:HEX2 show current y in hex.
//   HEX5:HEX4 are blank (7'h7F).
// - Undefined: all HEX outputs are constant 7'h7F (all segments off).
// STRUCTURE
// - Package task2_pkg holds:
//   - SCREEN_W, SCREEN_H, X_W = 8, Y_W = 7
//   - typedef enum logic [1:0] {INIT, FILL, DONE} fill_state_t
//   - 7-segment hex decode function (used only when the macro is defined)
// - Sub-module fill_engine: clk, rst_n, vga_x, vga_y, vga_colour, vga_plot, done.
//   It contains the FSM and the counters.
// - The top level does port mapping, tie-offs and the optional HEX decode.
// TESTING
// - Hold KEY[3]=0 for 5 clocks, release, count edges -> first plot cycle is (0,0,col 0);
//   LEDR[0]=1 on edge 19201.
// - Log every plot cycle -> exactly 19200 writes, each (x,y) unique, colour == x%8,
//   e.g. (9,5) has colour 1.
// - Column wrap: (0,119) is followed immediately by (1,0) with colour 1.
//   (7,119) -> (8,0) has colour 0.
// - Assert KEY[3]=0 at write ~5000, with no clock edge -> plot=0, LEDR[0]=0 immediately.
//   After release, fill restarts at (0,0) and completes in 19200 writes.
// - After done, run 1000 extra clocks -> VGA_PLOT stays 0, LEDR[0] stays 1,
//   LEDR[9:1]=0, SW toggling has no effect.
// - With FILL_HEX_STATUS_EN at x=0x9F, y=0x77 -> HEX1/HEX0 decode "9F",
//   HEX3/HEX2 decode "77". Without the macro, all HEX = 7'h7F.

Source files
------------

// File: rtl/task2_pkg.sv
// Shared definitions for the lab 2 fill-screen task.
//   - Screen geometry and counter widths.
//   - Fill FSM state encoding.
//   - Active-low 7-segment hex decoder. Only the optional status display
//     (FILL_HEX_STATUS_EN) uses it.
package task2_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  localparam logic [X_W-1:0] X_LAST    = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST    = Y_W'(SCREEN_H - 1);
  localparam logic [6:0]     HEX_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Segment order is {g,f,e,d,c,b,a}. A 0 lights the segment.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/task2_fill_engine.sv
// Frame fill engine. It writes each pixel of the screen exactly once, one per
// clock, in column-major order. Each pixel's colour is x[2:0].
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | one clock after reset release; the first pixel (0,0) is set up
//   FILL  | one pixel is presented per clock, with plot high
//   DONE  | frame complete; plot low, done high until the next reset
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   vga_x      out  pixel column, registered
//   vga_y      out  pixel row, registered
//   vga_colour out  pixel colour, registered
//   vga_plot   out  write strobe, registered
//   done       out  frame-complete flag, registered
module fill_engine
  import task2_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           done
);

  fill_state_t    state;
  fill_state_t    state_next;
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;
  logic           plot_next;
  logic           done_next;
  logic           last_px;

  // The pixel currently on the outputs is the final one of the frame.
  assign last_px = (vga_x == X_LAST) && (vga_y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = FILL;
      FILL:    if (last_px) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = INIT;
    endcase
  end

  // These are the values the outputs take on the next edge. The registers below
  // hold them, so every output is free of combinational glitches.
  always_comb begin
    x_next    = vga_x;
    y_next    = vga_y;
    plot_next = 1'b0;
    done_next = 1'b0;
    case (state)
      INIT: begin
        x_next    = '0;
        y_next    = '0;
        plot_next = 1'b1;
      end
      FILL: begin
        if (last_px) begin
          done_next = 1'b1;
        end else begin
          plot_next = 1'b1;
          if (vga_y == Y_LAST) begin
            y_next = '0;
            x_next = vga_x + X_W'(1);
          end else begin
            y_next = vga_y + Y_W'(1);
          end
        end
      end
      DONE: begin
        done_next = 1'b1;
      end
      default: begin
        x_next = '0;
        y_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_x      <= x_next;
      vga_y      <= y_next;
      vga_colour <= x_next[2:0];
      vga_plot   <= plot_next;
      done       <= done_next;
    end
  end

endmodule

// File: rtl/task2_fillscreen_top.sv
// Top level for the lab 2 fill-screen task. It maps board pins onto the fill
// engine and ties off the unused VGA analog pins.
//
// Optional feature, macro FILL_HEX_STATUS_EN:
//   defined   - HEX1:HEX0 show the current x and HEX3:HEX2 show the current y,
//               both in hex. HEX5:HEX4 are blank.
//   undefined - every HEX digit is blank (7'h7F).
//
// Ports:
//   CLOCK_50    in   50 MHz system clock
//   KEY[3]      in   asynchronous active-low reset; KEY[2:0] unused
//   SW          in   unused
//   LEDR        out  LEDR[0] = done, others 0
//   HEX0..HEX5  out  active-low 7-segment digits
//   VGA_R/G/B   out  tied 0
//   VGA_HS/VS   out  tied 1
//   VGA_CLK     out  tied 0
//   VGA_X/Y     out  pixel coordinate to the external adapter
//   VGA_COLOUR  out  pixel colour
//   VGA_PLOT    out  pixel write strobe
module task2_fillscreen_top
  import task2_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic [3:0]     KEY,
  input  logic [9:0]     SW,
  output logic [9:0]     LEDR,
  output logic [6:0]     HEX0,
  output logic [6:0]     HEX1,
  output logic [6:0]     HEX2,
  output logic [6:0]     HEX3,
  output logic [6:0]     HEX4,
  output logic [6:0]     HEX5,
  output logic [7:0]     VGA_R,
  output logic [7:0]     VGA_G,
  output logic [7:0]     VGA_B,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_CLK,
  output logic [X_W-1:0] VGA_X,
  output logic [Y_W-1:0] VGA_Y,
  output logic [2:0]     VGA_COLOUR,
  output logic           VGA_PLOT
);

  logic done;
  logic unused_inputs;

  assign unused_inputs = ^{KEY[2:0], SW};

  fill_engine u_fill_engine (
    .clk        (CLOCK_50),
    .rst_n      (KEY[3]),
    .vga_x      (VGA_X),
    .vga_y      (VGA_Y),
    .vga_colour (VGA_COLOUR),
    .vga_plot   (VGA_PLOT),
    .done       (done)
  );

  assign LEDR    = {9'b0, done};
  assign VGA_R   = '0;
  assign VGA_G   = '0;
  assign VGA_B   = '0;
  assign VGA_HS  = 1'b1;
  assign VGA_VS  = 1'b1;
  assign VGA_CLK = 1'b0;

`ifdef FILL_HEX_STATUS_EN
  assign HEX0 = hex7seg(VGA_X[3:0]);
  assign HEX1 = hex7seg(VGA_X[7:4]);
  assign HEX2 = hex7seg(VGA_Y[3:0]);
  assign HEX3 = hex7seg({1'b0, VGA_Y[6:4]});
  assign HEX4 = HEX_BLANK;
  assign HEX5 = HEX_BLANK;
`else
  assign HEX0 = HEX_BLANK;
  assign HEX1 = HEX_BLANK;
  assign HEX2 = HEX_BLANK;
  assign HEX3 = HEX_BLANK;
  assign HEX4 = HEX_BLANK;
  assign HEX5 = HEX_BLANK;
`endif

endmodule

// File: tb/tb_task2_fillscreen_top.sv
module tb_task2_fillscreen_top;

  localparam int W = 160;
  localparam int H = 120;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;

  logic       clk;
  logic [3:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_clk;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int  total = 0;
  int  bad   = 0;
  px_t sb[$];
  bit  seen[NPIX];

  task2_fillscreen_top dut (
    .CLOCK_50   (clk),
    .KEY        (key),
    .SW         (sw),
    .LEDR       (ledr),
    .HEX0       (hex0),
    .HEX1       (hex1),
    .HEX2       (hex2),
    .HEX3       (hex3),
    .HEX4       (hex4),
    .HEX5       (hex5),
    .VGA_R      (vga_r),
    .VGA_G      (vga_g),
    .VGA_B      (vga_b),
    .VGA_HS     (vga_hs),
    .VGA_VS     (vga_vs),
    .VGA_CLK    (vga_clk),
    .VGA_X      (vga_x),
    .VGA_Y      (vga_y),
    .VGA_COLOUR (vga_colour),
    .VGA_PLOT   (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment patterns, active low, {g..a}.
  function automatic logic [6:0] ref_seg(input int v);
    logic [6:0] t[16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v & 15];
  endfunction

  task automatic test_reset();
    key = 4'b0000;
    sw  = '0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({vga_x, vga_y, vga_colour, vga_plot} !== 19'd0) begin
      bad++;
      $display("FAIL reset_pixel x=%0d y=%0d c=%0d plot=%b want 0 0 0 0",
               vga_x, vga_y, vga_colour, vga_plot);
    end
    total++;
    if (ledr !== 10'd0) begin
      bad++;
      $display("FAIL reset_ledr got=%h want=000", ledr);
    end
    total++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_clk} !== {24'd0, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL tieoffs rgb=%h hs=%b vs=%b clk=%b want 0 1 1 0",
               {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_clk);
    end
  endtask

  // Fills the scoreboard, releases reset on a falling edge, and checks each plot
  // cycle. If stop_writes is nonzero, the task returns right after that many
  // writes, #1 past the clock edge.
  task automatic run_fill(input int stop_writes);
    int  edge_n;
    int  writes;
    int  done_edge;
    px_t got, exp_px, prev;
    bit  have_prev;
    sb.delete();
    for (int i = 0; i < NPIX; i++) seen[i] = 1'b0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        sb.push_back('{x: 8'(x), y: 7'(y), c: 3'(x % 8)});
    edge_n = 0; writes = 0; done_edge = 0; have_prev = 1'b0;
    @(negedge clk);
    key[3] = 1'b1;
    while (edge_n < NPIX + 50) begin
      @(posedge clk);
      #1;
      edge_n++;
      got = '{x: vga_x, y: vga_y, c: vga_colour};
      if (edge_n == 1) begin
        total++;
        if (vga_plot !== 1'b1 || got !== px_t'({8'd0, 7'd0, 3'd0})) begin
          bad++;
          $display("FAIL first_pixel plot=%b x=%0d y=%0d c=%0d want 1 0 0 0",
                   vga_plot, vga_x, vga_y, vga_colour);
        end
      end
      if (ledr[0] === 1'b1) begin
        done_edge = edge_n;
        break;
      end
      if (vga_plot !== 1'b1) begin
        total++; bad++;
        $display("FAIL plot_gap edge=%0d plot=%b want 1", edge_n, vga_plot);
        continue;
      end
      writes++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL extra_write x=%0d y=%0d want no write", vga_x, vga_y);
      end else begin
        exp_px = sb.pop_front();
        if (got !== exp_px) begin
          bad++;
          $display("FAIL pixel write=%0d got=(%0d,%0d,c%0d) want=(%0d,%0d,c%0d)",
                   writes, got.x, got.y, got.c, exp_px.x, exp_px.y, exp_px.c);
        end
      end
      if (vga_x < 8'(W) && vga_y < 7'(H)) begin
        if (seen[int'(vga_x) * H + int'(vga_y)]) begin
          total++; bad++;
          $display("FAIL duplicate x=%0d y=%0d want unique", vga_x, vga_y);
        end
        seen[int'(vga_x) * H + int'(vga_y)] = 1'b1;
      end else begin
        total++; bad++;
        $display("FAIL range x=%0d y=%0d want x<160 y<120", vga_x, vga_y);
      end
      if (got.x == 8'd9 && got.y == 7'd5) begin
        total++;
        if (got.c !== 3'd1) begin
          bad++;
          $display("FAIL colour_9_5 got=%0d want=1", got.c);
        end
      end
      if (have_prev && prev.y == 7'd119 && (prev.x == 8'd0 || prev.x == 8'd7)) begin
        total++;
        if (got !== px_t'({prev.x + 8'd1, 7'd0, 3'(prev.x + 8'd1)})) begin
          bad++;
          $display("FAIL column_wrap from x=%0d got=(%0d,%0d,c%0d) want=(%0d,0,c%0d)",
                   prev.x, got.x, got.y, got.c, prev.x + 8'd1, (prev.x + 8'd1) % 8);
        end
      end
      prev = got;
      have_prev = 1'b1;
      if (stop_writes != 0 && writes == stop_writes) return;
    end
    total++;
    if (done_edge != NPIX + 1) begin
      bad++;
      $display("FAIL done_edge got=%0d want=%0d", done_edge, NPIX + 1);
    end
    total++;
    if (writes != NPIX || sb.size() != 0) begin
      bad++;
      $display("FAIL write_count got=%0d left=%0d want=%0d left=0", writes, sb.size(), NPIX);
    end
    total++;
    if (vga_plot !== 1'b0 || vga_x !== 8'd159 || vga_y !== 7'd119) begin
      bad++;
      $display("FAIL done_pixel plot=%b x=%0d y=%0d want 0 159 119", vga_plot, vga_x, vga_y);
    end
  endtask

  task automatic test_full_fill();
    run_fill(0);
  endtask

  task automatic test_mid_reset();
    key[3] = 1'b0;
    repeat (3) @(posedge clk);
    run_fill(5000);
    #2;
    key[3] = 1'b0;
    #1;
    total++;
    if (vga_plot !== 1'b0 || ledr !== 10'd0 || vga_x !== 8'd0 || vga_y !== 7'd0 ||
        vga_colour !== 3'd0) begin
      bad++;
      $display("FAIL async_reset plot=%b ledr=%h x=%0d y=%0d c=%0d want 0 000 0 0 0",
               vga_plot, ledr, vga_x, vga_y, vga_colour);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (vga_plot !== 1'b0 || ledr !== 10'd0) begin
      bad++;
      $display("FAIL held_reset plot=%b ledr=%h want 0 000", vga_plot, ledr);
    end
    run_fill(0);
  endtask

  task automatic test_done_hold();
    int errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      sw = 10'($urandom_range(0, 1023));
      key[2:0] = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      if (vga_plot !== 1'b0 || ledr !== 10'h001 || vga_x !== 8'd159 || vga_y !== 7'd119)
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL done_hold bad_cycles=%0d plot=%b ledr=%h want 0 cycles, 0 001",
               errs, vga_plot, ledr);
    end
  endtask

  task automatic test_hex();
    logic [41:0] got, exp_hex;
    got = {hex5, hex4, hex3, hex2, hex1, hex0};
`ifdef FILL_HEX_STATUS_EN
    exp_hex = {7'h7F, 7'h7F, ref_seg(7), ref_seg(7), ref_seg(9), ref_seg(15)};
`else
    exp_hex = {6{7'h7F}};
`endif
    total++;
    if (got !== exp_hex) begin
      bad++;
      $display("FAIL hex_done got=%h want=%h", got, exp_hex);
    end
    @(negedge clk);
    key[3] = 1'b0;
    #1;
    got = {hex5, hex4, hex3, hex2, hex1, hex0};
`ifdef FILL_HEX_STATUS_EN
    exp_hex = {7'h7F, 7'h7F, ref_seg(0), ref_seg(0), ref_seg(0), ref_seg(0)};
`else
    exp_hex = {6{7'h7F}};
`endif
    total++;
    if (got !== exp_hex) begin
      bad++;
      $display("FAIL hex_reset got=%h want=%h", got, exp_hex);
    end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_mid_reset();
    test_done_hold();
    test_hex();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
